// File: rtl/gate_seq_pkg.sv
// Shared constants for the gate-block self-test sequencer: FSM encoding,
// the golden truth table and the bit layout of the gate return bus.
package gate_seq_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DRIVE  = 2'd1,
      FINISH = 2'd2
   } state_t;

   // Golden capture, byte idx holds the eight gate outputs for {A,B}=idx
   localparam logic [31:0] EXP_TABLE = 32'h95595AAA;

   // Bit positions on the gate return bus
   localparam int BUF_BIT  = 0;
   localparam int NOT_BIT  = 1;
   localparam int AND_BIT  = 2;
   localparam int NAND_BIT = 3;
   localparam int OR_BIT   = 4;
   localparam int NOR_BIT  = 5;
   localparam int XOR_BIT  = 6;
   localparam int XNOR_BIT = 7;

   // Expected gate byte for one vector, taken from the golden table
   function automatic logic [7:0] exp_byte(input logic [1:0] idx);
      return EXP_TABLE[8*idx +: 8];
   endfunction

   // Gate byte derived from boolean behaviour; Buf/Not observe operand A
   function automatic logic [7:0] gate_ref(input logic a, input logic b);
      logic [7:0] r;
      r           = '0;
      r[BUF_BIT]  = a;
      r[NOT_BIT]  = ~a;
      r[AND_BIT]  = a & b;
      r[NAND_BIT] = ~(a & b);
      r[OR_BIT]   = a | b;
      r[NOR_BIT]  = ~(a | b);
      r[XOR_BIT]  = a ^ b;
      r[XNOR_BIT] = ~(a ^ b);
      return r;
   endfunction

endpackage

// File: rtl/dwell_timer.sv
// Dwell counter: counts while enabled, flags the last cycle of each dwell
// window and wraps to zero there so back-to-back windows need no clear.
module dwell_timer
#(
   parameter int DWELL = 4,
   parameter int CNT_W = 8
)
(
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic tc
);

   if (DWELL < 1 || DWELL > 255) begin : g_bad_dwell
      $error("dwell_timer: DWELL must lie in 1..255");
   end
   if ((64'd1 << CNT_W) <= 64'(DWELL)) begin : g_bad_cnt_w
      $error("dwell_timer: CNT_W too narrow for DWELL");
   end

   localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(DWELL - 1);

   logic [CNT_W-1:0] cnt;

   // Terminal count only meaningful while the window is running
   assign tc = en && (cnt == TC_VAL);

   // Counter: clear on launch, wrap at terminal count, otherwise increment
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (en)
         cnt <= tc ? '0 : cnt + 1'b1;
   end

endmodule

// File: rtl/gate_vector_sequencer.sv
// Gate-block self-test: walks {A,B} through 00,01,10,11, holds each vector
// for DWELL cycles, captures the eight gate outputs at the end of each dwell
// and grades the captured truth table against the golden one.
module gate_vector_sequencer
   import gate_seq_pkg::*;
#(
   parameter int DWELL = 4,
   parameter int CNT_W = 8
)
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [7:0]  gate_in,
   output logic        A,
   output logic        B,
   output logic        busy,
   output logic        done,
   output logic [31:0] table_out,
   output logic [3:0]  err_mask,
   output logic        pass
);

   if (DWELL < 1 || DWELL > 255) begin : g_bad_dwell
      $error("gate_vector_sequencer: DWELL must lie in 1..255");
   end

   // The literal golden table must agree with the boolean gate definitions
   for (genvar g = 0; g < 4; g++) begin : g_exp_chk
      if (gate_ref(1'(g / 2), 1'(g % 2)) != EXP_TABLE[8*g +: 8]) begin : g_bad
         $error("gate_vector_sequencer: EXP_TABLE inconsistent with gate map");
      end
   end

   state_t     state, state_nxt;
   logic [1:0] idx;
   logic       accept;
   logic       tc;
   logic       sample;
   logic [3:0] err_upd;

   dwell_timer #(
      .DWELL (DWELL),
      .CNT_W (CNT_W)
   ) u_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (accept),
      .en    (state == DRIVE),
      .tc    (tc)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next state; start is only honoured in IDLE, so no run is ever queued
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_nxt = DRIVE;
               accept    = 1'b1;
            end
         end
         DRIVE:   if (tc && idx == 2'd3) state_nxt = FINISH;
         FINISH:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign sample = (state == DRIVE) && tc;
   assign busy   = (state == DRIVE);
   assign done   = (state == FINISH);

   // The vector index is the stimulus itself: A is the high bit, B the low
   assign A = idx[1];
   assign B = idx[0];

   // Error mask with the current vector's verdict merged in; also feeds pass
   always_comb begin
      err_upd      = err_mask;
      err_upd[idx] = (gate_in != exp_byte(idx));
   end

   // Capture/grade datapath; results hold from done until the next launch
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx       <= '0;
         table_out <= '0;
         err_mask  <= '0;
         pass      <= 1'b0;
      end else if (accept) begin
         idx       <= '0;
         table_out <= '0;
         err_mask  <= '0;
         pass      <= 1'b0;
      end else if (sample) begin
         table_out[8*idx +: 8] <= gate_in;
         err_mask              <= err_upd;
         if (idx != 2'd3)
            idx <= idx + 2'd1;
         else
            pass <= (err_upd == 4'd0);
      end
   end

endmodule
